instr_readback: RTL and testbench

Downstream readback stage for the 32-entry instruction register. On a start pulse it walks `read_pointer` across a window of entries, registers each `instruction_word` it gets back and hands it to a consumer over a valid/ready handshake. It signals completion with a one-cycle `done` pulse. Optionally it recomputes each entry's result and flags and counts mismatches.

---
 rtl/instr_readback.sv | 171 +++++++++++++++++
 tb/tb_instr_readback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_readback.sv
// rtl/instr_readback.sv - instruction register readback stage with optional result checking (READBACK_RESULT_CHECK_EN)

package instr_readback_pkg;
    typedef logic [4:0] address_t;

    typedef enum logic [2:0] {
        PASSA = 3'd0,
        PASSB = 3'd1,
        ADD   = 3'd2,
        SUB   = 3'd3,
        MULT  = 3'd4,
        DIV   = 3'd5,
        MOD   = 3'd6,
        ZERO  = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t            opc;
        logic signed [7:0]  op_a;
        logic signed [7:0]  op_b;
        logic signed [15:0] rez;
    } instruction_t;
endpackage

module instr_readback
    import instr_readback_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_ptr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_word,
    output address_t     out_index,
    output logic         out_mismatch,
    output logic         busy,
    output logic         done,
    output logic [5:0]   err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] MAX_COUNT = 6'(DEPTH);

    state_t       r_state;
    state_t       w_next;
    address_t     r_ptr;
    logic [5:0]   r_remaining;
    logic         r_out_valid;
    instruction_t r_out_word;
    address_t     r_out_index;
    logic         r_mismatch;
    logic [5:0]   r_err;
    logic [5:0]   w_count_clamped;
    logic         w_handshake;
    logic         w_mismatch;

    assign w_count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign w_handshake     = r_out_valid && out_ready;

`ifdef READBACK_RESULT_CHECK_EN
    logic signed [15:0] w_a;
    logic signed [15:0] w_b;
    logic signed [15:0] w_expected;
    logic               w_skip;

    // Recompute the entry's result in 16-bit signed arithmetic; DIV/MOD by zero is not checked
    always_comb begin
        w_a        = {{8{instruction_word.op_a[7]}}, instruction_word.op_a};
        w_b        = {{8{instruction_word.op_b[7]}}, instruction_word.op_b};
        w_expected = '0;
        w_skip     = 1'b0;
        case (instruction_word.opc)
            PASSA: w_expected = w_a;
            PASSB: w_expected = w_b;
            ADD:   w_expected = w_a + w_b;
            SUB:   w_expected = w_a - w_b;
            MULT:  w_expected = w_a * w_b;
            DIV: begin
                if (w_b == 16'sd0) w_skip = 1'b1;
                else               w_expected = w_a / w_b;
            end
            MOD: begin
                if (w_b == 16'sd0) w_skip = 1'b1;
                else               w_expected = w_a % w_b;
            end
            default: w_expected = '0;
        endcase
        w_mismatch = !w_skip && (w_expected != instruction_word.rez);
    end
`else
    assign w_mismatch = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (count == 6'd0) ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_HOLD;
            S_HOLD:  if (w_handshake) w_next = (r_remaining == 6'd1) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer, capture register and error counter updates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_index <= '0;
            r_mismatch  <= 1'b0;
            r_err       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr       <= first_ptr;
                        r_remaining <= w_count_clamped;
                        r_err       <= '0;
                    end
                end
                S_FETCH: begin
                    r_out_word  <= instruction_word;
                    r_out_index <= r_ptr;
                    r_mismatch  <= w_mismatch;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_ptr       <= r_ptr + 5'd1;
                        r_remaining <= r_remaining - 6'd1;
                        if (r_mismatch) r_err <= r_err + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_pointer = r_ptr;
    assign out_valid    = r_out_valid;
    assign out_word     = r_out_word;
    assign out_index    = r_out_index;
    assign out_mismatch = r_mismatch;
    assign err_count    = r_err;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_readback.sv
// tb/tb_instr_readback.sv - randomized self-checking bench for instr_readback

module tb_instr_readback;
    import instr_readback_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         start;
    address_t     first_ptr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    address_t     out_index;
    logic         out_mismatch;
    logic         busy;
    logic         done;
    logic [5:0]   err_count;

    instruction_t mem [32];
    int n_checks;
    int n_fail;

    instr_readback #(.DEPTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_ptr        (first_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word         (out_word),
        .out_index        (out_index),
        .out_mismatch     (out_mismatch),
        .busy             (busy),
        .done             (done),
        .err_count        (err_count)
    );

    assign instruction_word = mem[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_result(instruction_t w);
        int a;
        int b;
        a = int'($signed(w.op_a));
        b = int'($signed(w.op_b));
        case (w.opc)
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? 0 : a / b;
            MOD:     return (b == 0) ? 0 : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_mismatch(instruction_t w);
        int r;
        bit skip;
        bit mm;
        r    = ref_result(w);
        skip = ((w.opc == DIV) || (w.opc == MOD)) && (w.op_b == 8'sd0);
        mm   = !skip && (r[15:0] != w.rez);
`ifdef READBACK_RESULT_CHECK_EN
        return mm;
`else
        return mm && 1'b0;
`endif
    endfunction

    function automatic instruction_t mk(opcode_t o, int a, int b, int z);
        instruction_t w;
        w.opc  = o;
        w.op_a = 8'(a);
        w.op_b = 8'(b);
        w.rez  = 16'(z);
        return w;
    endfunction

    function automatic instruction_t rand_instr();
        instruction_t w;
        int r;
        w.opc  = opcode_t'($urandom_range(0, 7));
        w.op_a = 8'($urandom);
        w.op_b = ($urandom_range(0, 3) == 0) ? 8'sd0 : 8'($urandom);
        r      = ref_result(w);
        w.rez  = ($urandom_range(0, 1) == 1) ? r[15:0] : 16'($urandom);
        return w;
    endfunction

    // mode 0: ready always high, 1: random ready, 2: stall 5 cycles on the first word
    task automatic run(input address_t fp, input int cnt, input int mode);
        int           n;
        int           got;
        int           exp_err;
        int           cyc;
        int           stall_left;
        bit           seen_done;
        bit           hold_chk;
        bit           r;
        instruction_t held;
        address_t     held_idx;
        address_t     exp_idx;
        n          = (cnt > 32) ? 32 : cnt;
        got        = 0;
        exp_err    = 0;
        stall_left = 5;
        seen_done  = 0;
        hold_chk   = 0;
        @(negedge clk);
        first_ptr = fp;
        count     = 6'(cnt);
        start     = 1'b1;
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400) begin
            if (cyc == 1 && n > 0) check("fetch_ptr", 64'(read_pointer), 64'(fp));
            if (hold_chk) begin
                check("hold_word", 64'(out_word), 64'(held));
                check("hold_idx", 64'(out_index), 64'(held_idx));
                hold_chk = 0;
            end
            if (done) begin
                check("done_words", 64'(got), 64'(n));
                check("err_count", 64'(err_count), 64'(exp_err));
                if (mode == 0) check("done_cycle", 64'(cyc), 64'(2 * n + 1));
                seen_done = 1;
                break;
            end
            if (cyc <= 2) check("busy", 64'(busy), 64'd1);
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && stall_left > 0) begin
                        r = 1'b0;
                        stall_left--;
                    end else begin
                        r = 1'b1;
                    end
                end
            endcase
            out_ready = r;
            if (out_valid) begin
                if (mode == 0 && got == 0) check("valid_latency", 64'(cyc), 64'd2);
                if (r) begin
                    exp_idx = address_t'((int'(fp) + got) % 32);
                    check("out_index", 64'(out_index), 64'(exp_idx));
                    check("out_word", 64'(out_word), 64'(mem[exp_idx]));
                    check("out_mismatch", 64'(out_mismatch), 64'(ref_mismatch(mem[exp_idx])));
                    if (ref_mismatch(mem[exp_idx])) exp_err++;
                    got++;
                end else begin
                    held     = out_word;
                    held_idx = out_index;
                    hold_chk = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen_done) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("err_hold", 64'(err_count), 64'(exp_err));
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rp"}, 64'(read_pointer), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_word"}, 64'(out_word), 64'd0);
        check({tag, "_index"}, 64'(out_index), 64'd0);
        check({tag, "_mm"}, 64'(out_mismatch), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
    endtask

    initial begin
        int waited;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        first_ptr = '0;
        count     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        mem[0] = mk(ADD, 5, 3, 8);
        mem[1] = mk(SUB, 5, 3, 2);
        mem[2] = mk(MULT, 5, 3, 15);
        mem[3] = mk(PASSB, 5, 3, 3);
        run(5'd0, 4, 0);

        for (int i = 0; i < 32; i++) mem[i] = rand_instr();
        run(5'd30, 4, 0);
        run(5'd9, 0, 0);
        run(5'd12, 3, 2);

        mem[2] = mk(ADD, 2, 2, 5);
        mem[3] = mk(DIV, 9, 0, 77);
        run(5'd0, 4, 0);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_instr();
            run(address_t'($urandom_range(0, 31)), $urandom_range(0, 40), $urandom_range(0, 1));
        end
        run(5'd17, 45, 0);

        @(negedge clk);
        first_ptr = 5'd20;
        count     = 6'd8;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("reach_hold", 64'(out_valid), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrun");
        @(negedge clk);
        check("midrun_nodone", 64'(done), 64'd0);
        reset_n = 1'b1;
        run(5'd7, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
